// File: rtl/psum_rearrange_ctrl.sv
// -----------------------------------------------------------------------------
// psum_rearrange_ctrl
//
// Sequencer for the psum rearrange buffer. A job streams one finished output
// layer out of the psum SRAM (pixel-major, channel-inner order) and writes it
// into the rearrange buffer transposed to channel-major order. It then drains
// the buffer in linear address order to the next layer's ifmap loader over a
// valid/ready handshake.
//
// Ports
//   clock, reset          : rising-edge clock, asynchronous active-high reset
//   start                 : one-cycle job request, honoured only in IDLE
//   cfg_num_pix/_ch       : pixels per channel (P) / channels (C), latched on start
//   psum_rd_en/_addr      : psum SRAM read strobe and address (registered)
//   psum_data/_valid      : psum SRAM read data, valid one cycle after the strobe
//   buf_write_en/_addr    : rearrange buffer write port
//   buf_data_in/_valid    : rearrange buffer write data (valid == write enable)
//   buf_read_addr         : rearrange buffer read address (combinational read)
//   buf_data_out          : rearrange buffer read data
//   ifmap_data/_valid     : drained activation towards the ifmap loader
//   ifmap_ready           : ifmap loader accepts
//   busy                  : high while filling or draining
//   done                  : one-cycle pulse at job completion
//   cfg_err               : one-cycle pulse when a start is rejected
// -----------------------------------------------------------------------------
module psum_rearrange_ctrl #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 8,
   parameter int DEPTH  = 3500
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [9:0]        cfg_num_pix,
   input  logic [3:0]        cfg_num_ch,
   output logic              psum_rd_en,
   output logic [ADDR_W-1:0] psum_rd_addr,
   input  logic [DATA_W-1:0] psum_data,
   input  logic              psum_data_valid,
   output logic              buf_write_en,
   output logic              buf_data_in_valid,
   output logic [ADDR_W-1:0] buf_write_addr,
   output logic [DATA_W-1:0] buf_data_in,
   output logic [ADDR_W-1:0] buf_read_addr,
   input  logic [DATA_W-1:0] buf_data_out,
   output logic [DATA_W-1:0] ifmap_data,
   output logic              ifmap_valid,
   input  logic              ifmap_ready,
   output logic              busy,
   output logic              done,
   output logic              cfg_err
);

   // Job size arithmetic is 14 bits wide: 1023 * 15 still fits.
   localparam int               CNT_W     = 14;
   localparam logic [CNT_W-1:0] DEPTH_LIM = CNT_W'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FILL  = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t           state;
   logic [9:0]       pix_num;     // latched P
   logic [3:0]       ch_num;      // latched C
   logic [CNT_W-1:0] job_len;     // latched N = P*C
   logic [CNT_W-1:0] issue_cnt;   // psum reads issued so far
   logic [9:0]       wr_pix;      // p of the next psum element to write
   logic [3:0]       wr_ch;       // c of the next psum element to write
   logic [CNT_W-1:0] wr_ptr;      // c*P + p, built incrementally
   logic [CNT_W-1:0] wr_cnt;      // buffer writes done
   logic [CNT_W-1:0] rd_ptr;      // drain read counter r
   logic [CNT_W-1:0] hs_cnt;      // completed output handshakes

   logic [CNT_W-1:0] start_len;
   logic             start_ok;
   logic             wr_fire;
   logic             drain_load;
   logic             drain_hs;

   // Start validation, write-port pass-through and drain handshake decode.
   always_comb begin
      start_len  = CNT_W'(cfg_num_pix) * CNT_W'(cfg_num_ch);
      start_ok   = (cfg_num_pix != 10'd0) && (cfg_num_ch != 4'd0) &&
                   (start_len <= DEPTH_LIM);
      wr_fire    = (state == S_FILL) && psum_data_valid;
      drain_load = (state == S_DRAIN) && (!ifmap_valid || ifmap_ready) &&
                   (rd_ptr < job_len);
      drain_hs   = (state == S_DRAIN) && ifmap_valid && ifmap_ready;
      // Write data only passes through while filling, so reset forces it to 0.
      if (wr_fire) begin
         buf_write_en = 1'b1;
         buf_data_in  = psum_data;
      end else begin
         buf_write_en = 1'b0;
         buf_data_in  = '0;
      end
   end

   assign buf_data_in_valid = buf_write_en;
   assign buf_write_addr    = wr_ptr[ADDR_W-1:0];
   assign buf_read_addr     = rd_ptr[ADDR_W-1:0];

   // Job state machine with issue, transpose-write and drain datapaths.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state        <= S_IDLE;
         pix_num      <= 10'd0;
         ch_num       <= 4'd0;
         job_len      <= '0;
         issue_cnt    <= '0;
         wr_pix       <= 10'd0;
         wr_ch        <= 4'd0;
         wr_ptr       <= '0;
         wr_cnt       <= '0;
         rd_ptr       <= '0;
         hs_cnt       <= '0;
         psum_rd_en   <= 1'b0;
         psum_rd_addr <= '0;
         ifmap_data   <= '0;
         ifmap_valid  <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         cfg_err      <= 1'b0;
      end else begin
         done    <= 1'b0;
         cfg_err <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  if (start_ok) begin
                     pix_num      <= cfg_num_pix;
                     ch_num       <= cfg_num_ch;
                     job_len      <= start_len;
                     // First read goes out in the cycle right after start.
                     psum_rd_en   <= 1'b1;
                     psum_rd_addr <= '0;
                     issue_cnt    <= 14'd1;
                     wr_pix       <= 10'd0;
                     wr_ch        <= 4'd0;
                     wr_ptr       <= '0;
                     wr_cnt       <= '0;
                     rd_ptr       <= '0;
                     hs_cnt       <= '0;
                     busy         <= 1'b1;
                     state        <= S_FILL;
                  end else begin
                     cfg_err <= 1'b1;
                  end
               end
            end

            S_FILL: begin
               if (psum_rd_en) begin
                  if (issue_cnt == job_len) begin
                     psum_rd_en   <= 1'b0;
                     psum_rd_addr <= '0;
                  end else begin
                     psum_rd_addr <= issue_cnt[ADDR_W-1:0];
                     issue_cnt    <= issue_cnt + 14'd1;
                  end
               end
               if (wr_fire) begin
                  wr_cnt <= wr_cnt + 14'd1;
                  if (wr_cnt == job_len - 14'd1) begin
                     wr_ptr <= '0;
                     state  <= S_DRAIN;
                  end else if (wr_ch == ch_num - 4'd1) begin
                     // Last channel of this pixel: wrap to channel 0 of p+1.
                     wr_ptr <= CNT_W'(wr_pix) + 14'd1;
                     wr_pix <= wr_pix + 10'd1;
                     wr_ch  <= 4'd0;
                  end else begin
                     // Next channel of the same pixel lives one row (P) further.
                     wr_ptr <= wr_ptr + CNT_W'(pix_num);
                     wr_ch  <= wr_ch + 4'd1;
                  end
               end
            end

            S_DRAIN: begin
               if (drain_load) begin
                  ifmap_data  <= buf_data_out;
                  ifmap_valid <= 1'b1;
                  rd_ptr      <= rd_ptr + 14'd1;
               end else if (drain_hs) begin
                  ifmap_valid <= 1'b0;
               end
               if (drain_hs) begin
                  hs_cnt <= hs_cnt + 14'd1;
                  if (hs_cnt == job_len - 14'd1) begin
                     done  <= 1'b1;
                     busy  <= 1'b0;
                     state <= S_DONE;
                  end
               end
            end

            S_DONE: begin
               rd_ptr <= '0;
               state  <= S_IDLE;
            end

            default: begin
               psum_rd_en  <= 1'b0;
               ifmap_valid <= 1'b0;
               busy        <= 1'b0;
               state       <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_psum_rearrange_ctrl.sv
// -----------------------------------------------------------------------------
// tb_psum_rearrange_ctrl
//
// Self-checking bench for psum_rearrange_ctrl. Models the psum SRAM (one-cycle
// read latency) and the rearrange buffer (combinational read) as plain arrays.
// Expected buffer write addresses and the drained output order are computed
// directly from the transpose rule: psum element k (p=k/C, c=k%C) belongs at
// c*P+p, and the drain emits channel 0 pixels 0..P-1, then channel 1, ...
// -----------------------------------------------------------------------------
module tb_psum_rearrange_ctrl;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [9:0]  cfg_num_pix = 10'd0;
   logic [3:0]  cfg_num_ch = 4'd0;
   logic        psum_rd_en;
   logic [11:0] psum_rd_addr;
   logic [7:0]  psum_data;
   logic        psum_data_valid;
   logic        buf_write_en;
   logic        buf_data_in_valid;
   logic [11:0] buf_write_addr;
   logic [7:0]  buf_data_in;
   logic [11:0] buf_read_addr;
   logic [7:0]  buf_data_out;
   logic [7:0]  ifmap_data;
   logic        ifmap_valid;
   logic        ifmap_ready = 1'b0;
   logic        busy;
   logic        done;
   logic        cfg_err;

   psum_rearrange_ctrl #(.ADDR_W(12), .DATA_W(8), .DEPTH(3500)) dut (
      .clock(clock), .reset(reset), .start(start),
      .cfg_num_pix(cfg_num_pix), .cfg_num_ch(cfg_num_ch),
      .psum_rd_en(psum_rd_en), .psum_rd_addr(psum_rd_addr),
      .psum_data(psum_data), .psum_data_valid(psum_data_valid),
      .buf_write_en(buf_write_en), .buf_data_in_valid(buf_data_in_valid),
      .buf_write_addr(buf_write_addr), .buf_data_in(buf_data_in),
      .buf_read_addr(buf_read_addr), .buf_data_out(buf_data_out),
      .ifmap_data(ifmap_data), .ifmap_valid(ifmap_valid), .ifmap_ready(ifmap_ready),
      .busy(busy), .done(done), .cfg_err(cfg_err)
   );

   always #5 clock = ~clock;

   // Environment memories
   logic [7:0] psum_mem [0:4095];
   logic [7:0] buf_mem  [0:4095];

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         psum_data_valid <= 1'b0;
         psum_data       <= 8'd0;
      end else begin
         psum_data_valid <= psum_rd_en;
         psum_data       <= psum_mem[psum_rd_addr];
      end
   end

   always @(posedge clock) begin
      if (buf_write_en) buf_mem[buf_write_addr] <= buf_data_in;
   end

   assign buf_data_out = buf_mem[buf_read_addr];

   // Reference expectations and bookkeeping
   logic [7:0] exp_seq[$];
   int         exp_waddr[$];
   int checks = 0;
   int errors = 0;
   int mon_t = 0, rd_cnt = 0, wr_cnt = 0, hs_cnt = 0, done_cnt = 0, cfg_cnt = 0;
   int rd_first = 0, rd_last = 0, wr_first = 0, vld_first = 0, done_t = 0;
   int hs_last = 0, cfg_t = 0;
   bit busy_seen = 1'b0;
   bit prev_stall = 1'b0;
   logic [7:0]  prev_data = 8'd0;
   logic [11:0] prev_raddr = 12'd0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expd);
      checks++;
      assert (obs === expd) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expd);
      end
   endtask

   // Per-cycle monitor, sampled on the falling edge.
   always @(negedge clock) begin
      if (!reset) begin
         mon_t++;
         if (psum_rd_en) begin
            if (rd_cnt == 0) rd_first = mon_t;
            rd_last = mon_t;
            chk("rd_addr", {20'd0, psum_rd_addr}, rd_cnt);
            rd_cnt++;
         end
         if (buf_write_en) begin
            if (wr_cnt == 0) wr_first = mon_t;
            if (wr_cnt < exp_waddr.size())
               chk("wr_addr", {20'd0, buf_write_addr}, exp_waddr[wr_cnt]);
            else
               chk("wr_extra", wr_cnt, exp_waddr.size());
            chk("wr_data_valid", {31'd0, buf_data_in_valid}, 32'd1);
            wr_cnt++;
         end
         if (ifmap_valid && vld_first == 0) vld_first = mon_t;
         if (prev_stall) begin
            chk("hold_valid", {31'd0, ifmap_valid}, 32'd1);
            chk("hold_data", {24'd0, ifmap_data}, {24'd0, prev_data});
            chk("hold_raddr", {20'd0, buf_read_addr}, {20'd0, prev_raddr});
         end
         if (ifmap_valid && ifmap_ready) begin
            if (hs_cnt < exp_seq.size())
               chk("ifmap_data", {24'd0, ifmap_data}, {24'd0, exp_seq[hs_cnt]});
            else
               chk("hs_extra", hs_cnt, exp_seq.size());
            hs_cnt++;
            hs_last = mon_t;
         end
         prev_stall = ifmap_valid && !ifmap_ready;
         prev_data  = ifmap_data;
         prev_raddr = buf_read_addr;
         if (done) begin
            done_cnt++;
            done_t = mon_t;
         end
         if (cfg_err) begin
            cfg_cnt++;
            cfg_t = mon_t;
         end
         if (done || cfg_err) chk("done_cfg_excl", {31'd0, done & cfg_err}, 32'd0);
         if (busy) busy_seen = 1'b1;
      end else begin
         prev_stall = 1'b0;
      end
   end

   // Clears bookkeeping and issues a one-cycle start pulse; mon_t=1 is the
   // cycle right after the edge that samples start.
   task automatic pulse_start(input int p, input int c);
      @(posedge clock); #1;
      rd_cnt = 0; wr_cnt = 0; hs_cnt = 0; done_cnt = 0; cfg_cnt = 0;
      rd_first = 0; rd_last = 0; wr_first = 0; vld_first = 0; done_t = 0;
      hs_last = 0; cfg_t = 0; busy_seen = 1'b0;
      cfg_num_pix = 10'(p);
      cfg_num_ch  = 4'(c);
      start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      mon_t = 0;
   endtask

   // dmode: 0 -> data k, 1 -> random, 2 -> psum_mem preloaded by caller
   task automatic start_job(input int p, input int c, input int dmode);
      int n = p * c;
      exp_seq.delete();
      exp_waddr.delete();
      for (int k = 0; k < n; k++) begin
         if (dmode == 0) psum_mem[k] = 8'(k);
         else if (dmode == 1) psum_mem[k] = 8'($urandom);
         exp_waddr.push_back((k % c) * p + k / c);
      end
      for (int cc = 0; cc < c; cc++)
         for (int pp = 0; pp < p; pp++)
            exp_seq.push_back(psum_mem[pp * c + cc]);
      pulse_start(p, c);
   endtask

   // rmode: 0 -> ready high, 1 -> ready 1,0,0 repeating, 2 -> random ready
   task automatic run_job(input int p, input int c, input int rmode, input int dmode,
                          input bit inject);
      int n = p * c;
      int budget = 6 * n + 50;
      bit fin = 1'b0;
      ifmap_ready = (rmode == 0);
      start_job(p, c, dmode);
      for (int i = 0; i < budget && !fin; i++) begin
         @(posedge clock); #1;
         if (rmode == 0) ifmap_ready = 1'b1;
         else if (rmode == 1) ifmap_ready = (i % 3 == 0);
         else ifmap_ready = 1'($urandom_range(0, 1));
         start = inject && (i == n / 2 || i == n + n / 2 + 2);
         if (done_cnt != 0) fin = 1'b1;
      end
      start = 1'b0;
      chk("job_finished", {31'd0, fin}, 32'd1);
      repeat (6) @(posedge clock);
      #1;
      chk("rd_count", rd_cnt, n);
      chk("rd_first", rd_first, 1);
      chk("rd_last", rd_last, n);
      chk("wr_count", wr_cnt, n);
      chk("wr_first", wr_first, 2);
      chk("hs_count", hs_cnt, n);
      chk("done_count", done_cnt, 1);
      chk("done_after_last_hs", done_t, hs_last + 1);
      chk("no_cfg_err", cfg_cnt, 0);
      chk("busy_end", {31'd0, busy}, 32'd0);
      if (rmode == 0) begin
         chk("first_valid_time", vld_first, n + 3);
         chk("done_time", done_t, 2 * n + 3);
      end
      ifmap_ready = 1'b0;
   endtask

   task automatic cfg_err_test(input int p, input int c);
      pulse_start(p, c);
      repeat (4) @(posedge clock);
      #1;
      chk("cfg_err_count", cfg_cnt, 1);
      chk("cfg_err_time", cfg_t, 1);
      chk("cfg_no_rd", rd_cnt, 0);
      chk("cfg_no_busy", {31'd0, busy_seen}, 32'd0);
      chk("cfg_no_done", done_cnt, 0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_rd"}, {19'd0, psum_rd_en, psum_rd_addr}, 32'd0);
      chk({tag, "_wr"}, {2'd0, buf_write_en, buf_data_in_valid, buf_write_addr,
                         buf_data_in, 8'd0}, 32'd0);
      chk({tag, "_raddr"}, {20'd0, buf_read_addr}, 32'd0);
      chk({tag, "_ifmap"}, {23'd0, ifmap_valid, ifmap_data}, 32'd0);
      chk({tag, "_status"}, {29'd0, busy, done, cfg_err}, 32'd0);
   endtask

   initial begin
      bit reached;
      for (int k = 0; k < 4096; k++) begin
         psum_mem[k] = 8'd0;
         buf_mem[k]  = 8'd0;
      end
      #2;
      chk_all_zero("reset_state");
      repeat (2) @(negedge clock);
      reset = 1'b0;

      // Basic P=4 C=2 with data k, then the same job under backpressure
      run_job(4, 2, 0, 0, 1'b0);
      run_job(4, 2, 1, 0, 1'b0);
      // Starts mid-FILL and mid-DRAIN must be ignored
      run_job(8, 3, 0, 1, 1'b1);
      // Rejected configurations
      cfg_err_test(5, 0);
      cfg_err_test(0, 3);
      cfg_err_test(600, 6);
      // Full-size job
      run_job(576, 6, 0, 1, 1'b0);
      // Random shapes under random backpressure
      for (int j = 0; j < 3; j++)
         run_job(int'($urandom_range(1, 60)), int'($urandom_range(1, 15)), 2, 1, 1'b0);

      // Async reset between edges in the middle of a drain
      ifmap_ready = 1'b1;
      start_job(4, 2, 0);
      reached = 1'b0;
      for (int i = 0; i < 100 && !reached; i++) begin
         @(posedge clock); #1;
         if (hs_cnt >= 3) reached = 1'b1;
      end
      chk("reached_drain", {31'd0, reached}, 32'd1);
      @(negedge clock); #2;
      reset = 1'b1;
      #1;
      chk_all_zero("async_reset");
      @(negedge clock); #2;
      reset = 1'b0;
      repeat (5) @(posedge clock);
      #1;
      chk("no_done_after_abort", done_cnt, 0);
      ifmap_ready = 1'b0;

      // Follow-up job P=2 C=1 with data 5, -3
      psum_mem[0] = 8'd5;
      psum_mem[1] = 8'hFD;
      run_job(2, 1, 0, 2, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
